// File: rtl/latch_edge_monitor.sv
// -----------------------------------------------------------------------------
// latch_edge_monitor
//
// Purpose:
//   Brings the output of a level-sensitive D-latch into the clk domain and
//   turns it into clean, glitch-free information for downstream sequential
//   logic. The path is: synchroniser chain -> persistence filter -> edge
//   detector / saturating transition counter. The latch output is treated as
//   fully asynchronous to clk.
//
// Parameters:
//   SYNC_STAGES : number of synchroniser flops (2 or more)
//   FILTER_LEN  : clk cycles a new synchronised level must persist before it
//                 is accepted onto q_sync (1 or more)
//   CNT_W       : width of the accepted-transition counter
//
// Ports:
//   clk       in   system clock, all state updates on the rising edge
//   reset     in   synchronous, active-high; dominates every other input
//   data_in   in   latch output q, asynchronous to clk
//   clear_cnt in   synchronous clear of edge_cnt / cnt_sat
//   q_sync    out  filtered, synchronised level
//   rise      out  one-cycle pulse in the first cycle q_sync shows 1
//   fall      out  one-cycle pulse in the first cycle q_sync shows 0
//   edge_cnt  out  saturating count of accepted transitions
//   cnt_sat   out  high while edge_cnt is at its maximum value
// -----------------------------------------------------------------------------
module latch_edge_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_in,
  input  logic             clear_cnt,
  output logic             q_sync,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             cnt_sat
);

  // Filter counter only has to reach FILTER_LEN-1; keep at least one bit so
  // the FILTER_LEN=1 configuration still elaborates cleanly.
  localparam int               FC_W    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FC_W-1:0]  FC_LAST = FC_W'(FILTER_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [0:0] {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  // synchroniser
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_out_s;

  // filter FSM
  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [FC_W-1:0]        fcnt_r;
  logic [FC_W-1:0]        fcnt_nxt_s;
  logic                   mismatch_s;
  logic                   accept_s;

  // registered outputs and their next values
  logic                   q_sync_r;
  logic                   q_sync_nxt_s;
  logic                   rise_r;
  logic                   rise_nxt_s;
  logic                   fall_r;
  logic                   fall_nxt_s;
  logic [CNT_W-1:0]       edge_cnt_r;
  logic [CNT_W-1:0]       edge_cnt_nxt_s;
  logic [CNT_W-1:0]       cnt_base_s;
  logic                   cnt_sat_r;
  logic                   cnt_sat_nxt_s;

  // Synchroniser: plain shift chain, nothing between stages so every flop
  // gets a full clock period to resolve metastability.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], data_in};
    end
  end

  assign sync_out_s = sync_r[SYNC_STAGES-1];

  // A mismatch is accepted only on the cycle the counter has already seen
  // FILTER_LEN-1 earlier mismatching cycles, i.e. the FILTER_LEN-th in a row.
  assign mismatch_s = (sync_out_s != q_sync_r);
  assign accept_s   = mismatch_s && (fcnt_r == FC_LAST);

  // Filter FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_STABLE;
      fcnt_r  <= {FC_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      fcnt_r  <= fcnt_nxt_s;
    end
  end

  // Filter FSM next-state logic. Both states react identically to the
  // synchronised input; the state records whether a candidate level is
  // being timed. Any match discards the partial count, so a glitch shorter
  // than FILTER_LEN synchronised cycles leaves no trace.
  always_comb begin
    state_nxt_s = ST_STABLE;
    fcnt_nxt_s  = {FC_W{1'b0}};
    case (state_r)
      ST_STABLE, ST_PENDING: begin
        if (!mismatch_s) begin
          state_nxt_s = ST_STABLE;
          fcnt_nxt_s  = {FC_W{1'b0}};
        end else if (accept_s) begin
          state_nxt_s = ST_STABLE;
          fcnt_nxt_s  = {FC_W{1'b0}};
        end else begin
          state_nxt_s = ST_PENDING;
          fcnt_nxt_s  = fcnt_r + FC_W'(1);
        end
      end
      default: begin
        state_nxt_s = ST_STABLE;
        fcnt_nxt_s  = {FC_W{1'b0}};
      end
    endcase
  end

  // Output logic: next values for q_sync, the edge pulses and the counter.
  // Pulses are derived from the pre-toggle q_sync so they land in the same
  // cycle the new level first appears. Clear is applied before the
  // increment, so a clear coinciding with a toggle leaves a count of one.
  always_comb begin
    q_sync_nxt_s = q_sync_r ^ accept_s;
    rise_nxt_s   = accept_s & ~q_sync_r;
    fall_nxt_s   = accept_s &  q_sync_r;

    if (clear_cnt) begin
      cnt_base_s = {CNT_W{1'b0}};
    end else begin
      cnt_base_s = edge_cnt_r;
    end

    if (accept_s && (cnt_base_s != CNT_MAX)) begin
      edge_cnt_nxt_s = cnt_base_s + CNT_W'(1);
    end else begin
      edge_cnt_nxt_s = cnt_base_s;
    end

    cnt_sat_nxt_s = (edge_cnt_nxt_s == CNT_MAX);
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_sync_r   <= 1'b0;
      rise_r     <= 1'b0;
      fall_r     <= 1'b0;
      edge_cnt_r <= {CNT_W{1'b0}};
      cnt_sat_r  <= 1'b0;
    end else begin
      q_sync_r   <= q_sync_nxt_s;
      rise_r     <= rise_nxt_s;
      fall_r     <= fall_nxt_s;
      edge_cnt_r <= edge_cnt_nxt_s;
      cnt_sat_r  <= cnt_sat_nxt_s;
    end
  end

  assign q_sync   = q_sync_r;
  assign rise     = rise_r;
  assign fall     = fall_r;
  assign edge_cnt = edge_cnt_r;
  assign cnt_sat  = cnt_sat_r;

  latch_edge_monitor_chk #(
    .CNT_W (CNT_W)
  ) u_chk (
    .clk      (clk),
    .reset    (reset),
    .q_sync   (q_sync_r),
    .rise     (rise_r),
    .fall     (fall_r),
    .edge_cnt (edge_cnt_r),
    .cnt_sat  (cnt_sat_r)
  );

endmodule

// -----------------------------------------------------------------------------
// latch_edge_monitor_chk
//
// Purpose:
//   Invariants of the monitor's registered outputs, kept apart from the
//   datapath. Contains only properties; has no outputs.
//
// Ports (all inputs): clk, reset, q_sync, rise, fall, edge_cnt, cnt_sat.
// -----------------------------------------------------------------------------
module latch_edge_monitor_chk #(
  parameter int CNT_W = 4
) (
  input logic             clk,
  input logic             reset,
  input logic             q_sync,
  input logic             rise,
  input logic             fall,
  input logic [CNT_W-1:0] edge_cnt,
  input logic             cnt_sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  a_no_rise_and_fall: assert property (@(posedge clk) disable iff (reset)
    !(rise && fall));

  a_rise_shows_high: assert property (@(posedge clk) disable iff (reset)
    rise |-> q_sync);

  a_fall_shows_low: assert property (@(posedge clk) disable iff (reset)
    fall |-> !q_sync);

  a_rise_single_cycle: assert property (@(posedge clk) disable iff (reset)
    rise |=> !rise);

  a_fall_single_cycle: assert property (@(posedge clk) disable iff (reset)
    fall |=> !fall);

  a_sat_matches_count: assert property (@(posedge clk) disable iff (reset)
    cnt_sat == (edge_cnt == CNT_MAX));

endmodule

// File: tb/tb_latch_edge_monitor.sv
// -----------------------------------------------------------------------------
// tb_latch_edge_monitor
//
// Directed stimulus pushes the expected pulse (kind, counter, saturation flag
// and the cycle window it must appear in) into a queue; an independent
// monitor pops an entry whenever the DUT raises rise or fall and compares.
// Any pulse with no queued expectation is reported as unexpected.
// -----------------------------------------------------------------------------
module tb_latch_edge_monitor;

  localparam int CNT_W = 4;

  logic             clk       = 1'b0;
  logic             reset     = 1'b1;
  logic             clear_cnt = 1'b0;
  logic             drv       = 1'b0;
  logic             use_lat   = 1'b0;
  logic             lat_en    = 1'b0;
  logic             lat_d     = 1'b0;
  logic             lat_rst   = 1'b0;
  logic             lat_q;
  logic             data_in;
  logic             q_sync;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] edge_cnt;
  logic             cnt_sat;

  typedef struct {
    logic             is_rise;
    logic [CNT_W-1:0] cnt;
    logic             sat;
    int               lo;
    int               hi;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   exp_cnt = 0;

  assign data_in = use_lat ? lat_q : drv;

  latch_edge_monitor dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .clear_cnt (clear_cnt),
    .q_sync    (q_sync),
    .rise      (rise),
    .fall      (fall),
    .edge_cnt  (edge_cnt),
    .cnt_sat   (cnt_sat)
  );

  always #5 clk = ~clk;

  // cycle index: at the negedge following rising edge n, cyc == n
  always @(posedge clk) cyc <= cyc + 1;

  // D-latch with reset feeding the DUT in the asynchronous scenario
  always @(lat_en or lat_d or lat_rst) begin
    if (lat_rst) lat_q = 1'b0;
    else if (lat_en) lat_q = lat_d;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got cycle %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rise || fall) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: got rise=%0b fall=%0b at cycle %0d expected no pulse",
                 rise, fall, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        chk("pulse_rise",     {31'd0, rise},     {31'd0, mon_e.is_rise});
        chk("pulse_fall",     {31'd0, fall},     {31'd0, ~mon_e.is_rise});
        chk("pulse_q_sync",   {31'd0, q_sync},   {31'd0, mon_e.is_rise});
        chk("pulse_edge_cnt", {28'd0, edge_cnt}, {28'd0, mon_e.cnt});
        chk("pulse_cnt_sat",  {31'd0, cnt_sat},  {31'd0, mon_e.sat});
        chk_rng("pulse_cycle", cyc, mon_e.lo, mon_e.hi);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic is_rise, input int cnt, input int lo, input int hi);
    exp_t e;
    e.is_rise = is_rise;
    e.cnt     = CNT_W'(cnt);
    e.sat     = (cnt == 15);
    e.lo      = lo;
    e.hi      = hi;
    sb_q.push_back(e);
  endtask

  // flip the driven input and expect the pulse 5 edges later
  task automatic push_toggle();
    drv = ~drv;
    exp_cnt = (exp_cnt == 15) ? 15 : exp_cnt + 1;
    push(drv, exp_cnt, cyc + 5, cyc + 5);
  endtask

  task automatic do_reset(input logic lvl, input int n);
    reset = 1'b1;
    drv   = lvl;
    tick(n);
    reset = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pulses still pending expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog");
  end

  int r_tab[13] = '{43, 83, 125, 175, 283, 325, 375, 483, 525, 575, 683, 725, 775};

  initial begin
    int m;
    int c0;
    int ex;

    // ---- 1: input high through reset, accepted 5 edges after release
    drv = 1'b1;
    repeat (3) begin
      tick(1);
      chk("t1_reset_q_sync", {31'd0, q_sync}, 32'd0);
    end
    chk("t1_reset_rise",     {31'd0, rise},     32'd0);
    chk("t1_reset_fall",     {31'd0, fall},     32'd0);
    chk("t1_reset_edge_cnt", {28'd0, edge_cnt}, 32'd0);
    chk("t1_reset_cnt_sat",  {31'd0, cnt_sat},  32'd0);
    reset = 1'b0;
    exp_cnt = 1;
    push(1'b1, 1, cyc + 5, cyc + 5);
    tick(4);
    chk("t1_q_sync_before", {31'd0, q_sync}, 32'd0);
    tick(2);
    chk("t1_rise_gone",  {31'd0, rise},     32'd0);
    chk("t1_q_sync",     {31'd0, q_sync},   32'd1);
    chk("t1_edge_cnt",   {28'd0, edge_cnt}, 32'd1);
    wait_drain(10);

    // ---- 2: 2-cycle pulse discarded, 3-cycle pulse accepted
    do_reset(1'b0, 2);
    tick(6);
    chk("t2_idle_q_sync", {31'd0, q_sync}, 32'd0);
    drv = 1'b1;
    tick(2);
    drv = 1'b0;
    tick(8);
    chk("t2_glitch_q_sync",   {31'd0, q_sync},   32'd0);
    chk("t2_glitch_edge_cnt", {28'd0, edge_cnt}, 32'd0);
    push_toggle();
    tick(3);
    push_toggle();
    tick(8);
    wait_drain(10);
    chk("t2_edge_cnt", {28'd0, edge_cnt}, 32'd2);
    chk("t2_q_sync",   {31'd0, q_sync},   32'd0);

    // ---- 3: 20 toggles, counter saturates at 15
    do_reset(1'b0, 2);
    tick(4);
    for (int i = 1; i <= 20; i++) begin
      push_toggle();
      tick(8);
      chk("t3_edge_cnt", {28'd0, edge_cnt}, (i < 15) ? i : 15);
      chk("t3_cnt_sat",  {31'd0, cnt_sat},  (i >= 15) ? 32'd1 : 32'd0);
    end
    wait_drain(10);
    chk("t3_final_edge_cnt", {28'd0, edge_cnt}, 32'd15);
    chk("t3_final_cnt_sat",  {31'd0, cnt_sat},  32'd1);

    // ---- 4: clear alone, then clear on the same edge as a rise at count 7
    push_toggle();
    tick(8);
    clear_cnt = 1'b1;
    tick(1);
    clear_cnt = 1'b0;
    exp_cnt = 0;
    chk("t4_clear_edge_cnt", {28'd0, edge_cnt}, 32'd0);
    chk("t4_clear_cnt_sat",  {31'd0, cnt_sat},  32'd0);
    chk("t4_clear_q_sync",   {31'd0, q_sync},   32'd1);
    repeat (7) begin
      push_toggle();
      tick(8);
    end
    chk("t4_pre_edge_cnt", {28'd0, edge_cnt}, 32'd7);
    chk("t4_pre_q_sync",   {31'd0, q_sync},   32'd0);
    drv = 1'b1;
    exp_cnt = 1;
    push(1'b1, 1, cyc + 5, cyc + 5);
    tick(4);
    clear_cnt = 1'b1;
    tick(1);
    clear_cnt = 1'b0;
    tick(1);
    chk("t4_edge_cnt", {28'd0, edge_cnt}, 32'd1);
    chk("t4_cnt_sat",  {31'd0, cnt_sat},  32'd0);
    chk("t4_q_sync",   {31'd0, q_sync},   32'd1);
    wait_drain(10);

    // ---- 5: reset while the filter is counting
    push_toggle();
    tick(8);
    wait_drain(10);
    drv = 1'b1;
    m = cyc;
    tick(3);
    reset = 1'b1;
    tick(1);
    chk("t5_reset_q_sync",   {31'd0, q_sync},   32'd0);
    chk("t5_reset_rise",     {31'd0, rise},     32'd0);
    chk("t5_reset_edge_cnt", {28'd0, edge_cnt}, 32'd0);
    chk("t5_reset_cycle",    cyc,               m + 4);
    tick(1);
    reset = 1'b0;
    exp_cnt = 1;
    push(1'b1, 1, cyc + 5, cyc + 5);
    tick(3);
    chk("t5_q_sync_before", {31'd0, q_sync}, 32'd0);
    wait_drain(10);
    chk("t5_edge_cnt", {28'd0, edge_cnt}, 32'd1);

    // ---- 6: driven from a D-latch (en every 25, d every 40, first d at 43)
    do_reset(1'b0, 2);
    tick(2);
    lat_rst = 1'b1;
    tick(1);
    lat_rst = 1'b0;
    use_lat = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 13; i++) begin
      ex = c0 + (r_tab[i] - 4) / 10 + 6;
      push((i % 2) == 0, i + 1, ex - 1, ex + 1);
    end
    #1;
    fork
      begin
        repeat (32) begin
          #25 lat_en = ~lat_en;
        end
      end
      begin
        #43 lat_d = ~lat_d;
        repeat (18) begin
          #40 lat_d = ~lat_d;
        end
      end
    join
    tick(1);
    wait_drain(30);
    chk("t6_edge_cnt", {28'd0, edge_cnt}, 32'd13);
    chk("t6_q_sync",   {31'd0, q_sync},   32'd1);
    chk("t6_cnt_sat",  {31'd0, cnt_sat},  32'd0);

    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
